// File: rtl/servant_irq_pkg.sv
// rtl/servant_irq_pkg.sv - shared register map, FSM encoding and latency width for the IRQ controller
package servant_irq_pkg;

    localparam logic [1:0] ADR_PENDING = 2'd0;
    localparam logic [1:0] ADR_ENABLE  = 2'd1;
    localparam logic [1:0] ADR_MODE    = 2'd2;
    localparam logic [1:0] ADR_STATUS  = 2'd3;

    localparam int LAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    function automatic logic [LAT_W-1:0] lat_sat_inc(input logic [LAT_W-1:0] v);
        return (&v) ? v : v + LAT_W'(1);
    endfunction

endpackage

// File: rtl/servant_irq_sync.sv
// rtl/servant_irq_sync.sv - per-source synchronizer with registered level and rising-edge outputs
module servant_irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;

    // level_o is the delayed copy so it stays cycle-aligned with the registered rise
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/servant_irq_ctrl.sv
// rtl/servant_irq_ctrl.sv - external interrupt aggregator with bus registers, service FSM and latency capture
module servant_irq_ctrl
    import servant_irq_pkg::*;
#(
    parameter int NSRC        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            wb_clk,
    input  logic            wb_rst_n,
    input  logic [NSRC-1:0] irq_src,
    input  logic [1:0]      i_wb_adr,
    input  logic [31:0]     i_wb_dat,
    input  logic            i_wb_we,
    input  logic            i_wb_cyc,
    output logic [31:0]     o_wb_rdt,
    output logic            o_wb_ack,
    input  logic            i_new_irq,
    input  logic            i_mret,
    output logic            ext_irq
);

    logic [NSRC-1:0] src_level, src_rise;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        servant_irq_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk    (wb_clk),
            .rst_n  (wb_rst_n),
            .async_i(irq_src[i]),
            .level_o(src_level[i]),
            .rise_o (src_rise[i])
        );
    end

    logic [NSRC-1:0]  pending_q, pending_d;
    logic [NSRC-1:0]  enable_q, enable_d;
    logic [NSRC-1:0]  mode_q, mode_d;
    irq_state_e       state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [LAT_W-1:0] lat_cap_q, lat_cap_d;
    logic             ext_irq_q, ext_irq_d;
    logic             ack_q, ack_d;
    logic [31:0]      rdt_q, rdt_d;

    logic             bus_acc, bus_wr, irq_any;
    logic [NSRC-1:0]  w1c;
    logic [31:0]      rd_val;
    logic             unused_dat;

    assign unused_dat = ^i_wb_dat[31:NSRC];

    always_comb begin
        bus_acc = i_wb_cyc & ~ack_q;
        bus_wr  = bus_acc & i_wb_we;
        ack_d   = bus_acc;

        rd_val = '0;
        case (i_wb_adr)
            ADR_PENDING: rd_val = 32'(pending_q);
            ADR_ENABLE:  rd_val = 32'(enable_q);
            ADR_MODE:    rd_val = 32'(mode_q);
            ADR_STATUS:  rd_val = {lat_cap_q, 14'd0, state_q};
            default:     rd_val = '0;
        endcase
        rdt_d = bus_acc ? rd_val : '0;

        enable_d = enable_q;
        mode_d   = mode_q;
        w1c      = '0;
        if (bus_wr) begin
            case (i_wb_adr)
                ADR_PENDING: w1c      = i_wb_dat[NSRC-1:0];
                ADR_ENABLE:  enable_d = i_wb_dat[NSRC-1:0];
                ADR_MODE:    mode_d   = i_wb_dat[NSRC-1:0];
                default:     ;
            endcase
        end

        // Edge bits: a fresh rise beats a simultaneous write-1-clear. Level bits track the source.
        pending_d = (mode_q & ((pending_q & ~w1c) | src_rise)) | (~mode_q & src_level);
    end

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        lat_cap_d = lat_cap_q;
        irq_any   = |(pending_q & enable_q);

        case (state_q)
            ST_IDLE: begin
                if (irq_any) begin
                    state_d = ST_ASSERT;
                    lat_d   = '0;
                end
            end
            ST_ASSERT: begin
                lat_d = lat_sat_inc(lat_q);
                if (i_new_irq) begin
                    state_d   = ST_SERVICE;
                    lat_cap_d = lat_sat_inc(lat_q);
                end else if (!irq_any) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (i_mret) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ext_irq_d = (state_d == ST_ASSERT);
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            state_q   <= ST_IDLE;
            lat_q     <= '0;
            lat_cap_q <= '0;
            ext_irq_q <= 1'b0;
            ack_q     <= 1'b0;
            rdt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            state_q   <= state_d;
            lat_q     <= lat_d;
            lat_cap_q <= lat_cap_d;
            ext_irq_q <= ext_irq_d;
            ack_q     <= ack_d;
            rdt_q     <= rdt_d;
        end
    end

    assign ext_irq  = ext_irq_q;
    assign o_wb_ack = ack_q;
    assign o_wb_rdt = rdt_q;

endmodule

// File: tb/tb_servant_irq_ctrl.sv
// tb/tb_servant_irq_ctrl.sv - randomized and directed bench for servant_irq_ctrl against a behavioural model
module tb_servant_irq_ctrl;

    localparam int N = 4;
    localparam int S = 2;

    logic          wb_clk = 1'b0;
    logic          wb_rst_n;
    logic [N-1:0]  irq_src;
    logic [1:0]    i_wb_adr;
    logic [31:0]   i_wb_dat;
    logic          i_wb_we;
    logic          i_wb_cyc;
    logic [31:0]   o_wb_rdt;
    logic          o_wb_ack;
    logic          i_new_irq;
    logic          i_mret;
    logic          ext_irq;

    always #5 wb_clk = ~wb_clk;

    servant_irq_ctrl #(
        .NSRC       (N),
        .SYNC_STAGES(S)
    ) dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .irq_src  (irq_src),
        .i_wb_adr (i_wb_adr),
        .i_wb_dat (i_wb_dat),
        .i_wb_we  (i_wb_we),
        .i_wb_cyc (i_wb_cyc),
        .o_wb_rdt (o_wb_rdt),
        .o_wb_ack (o_wb_ack),
        .i_new_irq(i_new_irq),
        .i_mret   (i_mret),
        .ext_irq  (ext_irq)
    );

    // Reference model: source samples delayed by S+1 edges feed the spec's pending rules
    logic [N-1:0] hist[$];
    logic [N-1:0] m_pend, m_en, m_mode;
    int           m_state;
    int unsigned  m_lat, m_cap;
    logic         m_ack;
    int           hi_run;
    int           tests = 0;
    int           fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        logic [15:0] c;
        logic [1:0]  s;
        c = m_cap[15:0];
        s = 2'(m_state);
        case (a)
            2'd0:    return 32'(m_pend);
            2'd1:    return 32'(m_en);
            2'd2:    return 32'(m_mode);
            default: return {c, 14'd0, s};
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (S + 2) hist.push_back('0);
        m_pend = '0; m_en = '0; m_mode = '0;
        m_state = 0; m_lat = 0; m_cap = 0; m_ack = 1'b0; hi_run = 0;
    endtask

    task automatic step();
        logic [N-1:0] lvl, rise, w1c, pend_n, en_n, mode_n;
        logic         acc, wr, any;
        logic [31:0]  rdt_n;
        int           st_n;
        int unsigned  lat_n, cap_n;
        lvl  = hist[1];
        rise = hist[1] & ~hist[0];
        acc  = i_wb_cyc && !m_ack;
        wr   = acc && i_wb_we;
        rdt_n  = acc ? m_reg(i_wb_adr) : 32'd0;
        en_n   = (wr && i_wb_adr == 2'd1) ? i_wb_dat[N-1:0] : m_en;
        mode_n = (wr && i_wb_adr == 2'd2) ? i_wb_dat[N-1:0] : m_mode;
        w1c    = (wr && i_wb_adr == 2'd0) ? i_wb_dat[N-1:0] : '0;
        pend_n = (m_mode & ((m_pend & ~w1c) | rise)) | (~m_mode & lvl);
        any    = |(m_pend & m_en);
        st_n = m_state; lat_n = m_lat; cap_n = m_cap;
        if (m_state == 0) begin
            if (any) begin st_n = 1; lat_n = 0; end
        end else if (m_state == 1) begin
            lat_n = (m_lat >= 32'd65535) ? 32'd65535 : m_lat + 1;
            if (i_new_irq) begin st_n = 2; cap_n = lat_n; end
            else if (!any) st_n = 0;
        end else if (i_mret) begin
            st_n = 0;
        end
        hist.push_back(irq_src);
        void'(hist.pop_front());
        @(posedge wb_clk);
        #1;
        m_pend = pend_n; m_en = en_n; m_mode = mode_n;
        m_state = st_n; m_lat = lat_n; m_cap = cap_n; m_ack = acc;
        hi_run = ext_irq ? hi_run + 1 : 0;
        check("ext_irq", 32'(ext_irq), 32'(st_n == 1));
        check("ack", 32'(o_wb_ack), 32'(acc));
        check("rdt", o_wb_rdt, rdt_n);
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        i_wb_cyc = 1'b1; i_wb_we = 1'b1; i_wb_adr = a; i_wb_dat = d;
        step();
        i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        step();
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
        i_wb_cyc = 1'b1; i_wb_we = 1'b0; i_wb_adr = a;
        step();
        d = o_wb_rdt;
        i_wb_cyc = 1'b0;
        step();
    endtask

    task automatic wait_ext(input logic lvl, input int max, output int n);
        n = 0;
        while (ext_irq !== lvl && n < max) begin
            step();
            n++;
        end
        check("wait_ext", 32'(ext_irq), 32'(lvl));
    endtask

    task automatic do_reset();
        #1 wb_rst_n = 1'b0;
        #1;
        check("rst_ext_irq", 32'(ext_irq), 32'd0);
        check("rst_ack", 32'(o_wb_ack), 32'd0);
        check("rst_rdt", o_wb_rdt, 32'd0);
        model_reset();
        #1 wb_rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        logic [15:0] prev_lat;
        int          n, exp_lat;

        wb_rst_n = 1'b0; irq_src = '0; i_wb_adr = '0; i_wb_dat = '0;
        i_wb_we = 1'b0; i_wb_cyc = 1'b0; i_new_irq = 1'b0; i_mret = 1'b0;
        model_reset();
        repeat (2) @(posedge wb_clk);
        #1;
        check("por_ext_irq", 32'(ext_irq), 32'd0);
        check("por_ack", 32'(o_wb_ack), 32'd0);
        check("por_rdt", o_wb_rdt, 32'd0);
        wb_rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            wb_read(2'(a), d);
            check("por_reg", d, 32'd0);
        end

        // Edge source 0: ext_irq rises S+3 cycles after the input edge
        wb_write(2'd1, 32'h1);
        wb_write(2'd2, 32'h1);
        n = 0;
        while (ext_irq !== 1'b1 && n < 20) begin
            irq_src[0] = (n < 5);
            step();
            n++;
        end
        irq_src[0] = 1'b0;
        check("rise_to_ext", n, S + 3);
        wb_read(2'd0, d);
        check("pending_edge", d, 32'h1);
        repeat (10) step();
        exp_lat = hi_run;
        i_new_irq = 1'b1; step(); i_new_irq = 1'b0;
        check("ext_after_new_irq", 32'(ext_irq), 32'd0);
        wb_read(2'd3, d);
        check("status_service", d, {exp_lat[15:0], 14'd0, 2'd2});

        // Clear then mret stays quiet; without clearing the FSM re-asserts 2 cycles after mret
        wb_write(2'd0, 32'h1);
        i_mret = 1'b1; step(); i_mret = 1'b0;
        repeat (4) step();
        check("quiet_after_mret", 32'(ext_irq), 32'd0);
        wb_read(2'd3, d);
        check("status_idle", d & 32'h3, 32'd0);
        irq_src[0] = 1'b1;
        wait_ext(1'b1, 20, n);
        irq_src[0] = 1'b0;
        i_new_irq = 1'b1; step(); i_new_irq = 1'b0;
        i_mret = 1'b1; step(); i_mret = 1'b0;
        n = 1;
        while (ext_irq !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("mret_reassert", n, 2);
        wb_write(2'd0, 32'h1);
        repeat (4) step();

        // Edge set and write-1-clear land on the same edge: set wins
        wb_write(2'd1, 32'h0);
        wb_write(2'd2, 32'h3);
        irq_src[1] = 1'b1;
        repeat (S + 1) step();
        wb_write(2'd0, 32'h2);
        wb_read(2'd0, d);
        check("set_beats_w1c", d & 32'h2, 32'h2);
        wb_write(2'd0, 32'h2);
        wb_read(2'd0, d);
        check("w1c_clears", d & 32'h2, 32'h0);
        irq_src[1] = 1'b0;

        // Level source withdrawn before service: back to IDLE, latency untouched
        wb_read(2'd3, d);
        prev_lat = d[31:16];
        wb_write(2'd2, 32'h0);
        wb_write(2'd1, 32'h4);
        irq_src[2] = 1'b1;
        wait_ext(1'b1, 20, n);
        irq_src[2] = 1'b0;
        wait_ext(1'b0, 20, n);
        repeat (2) step();
        wb_read(2'd3, d);
        check("level_withdraw", d, {prev_lat, 14'd0, 2'd0});

        // Reset while ASSERT, then while SERVICE
        wb_write(2'd2, 32'h1);
        wb_write(2'd1, 32'h1);
        irq_src[0] = 1'b1;
        wait_ext(1'b1, 20, n);
        irq_src[0] = 1'b0;
        do_reset();
        repeat (S + 3) step();
        wb_write(2'd2, 32'h1);
        wb_write(2'd1, 32'h1);
        irq_src[0] = 1'b1;
        wait_ext(1'b1, 20, n);
        irq_src[0] = 1'b0;
        i_new_irq = 1'b1; step(); i_new_irq = 1'b0;
        wb_read(2'd3, d);
        check("in_service", d & 32'h3, 32'h2);
        do_reset();
        for (int a = 0; a < 4; a++) begin
            wb_read(2'(a), d);
            check("post_rst_reg", d, 32'd0);
        end

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) irq_src = N'($urandom);
            i_new_irq = ($urandom_range(0, 9) == 0);
            i_mret    = ($urandom_range(0, 9) == 0);
            i_wb_cyc  = ($urandom_range(0, 3) == 0);
            i_wb_we   = ($urandom_range(0, 1) == 0);
            i_wb_adr  = 2'($urandom);
            i_wb_dat  = $urandom;
            if ($urandom_range(0, 599) == 0) do_reset();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
